// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//
// CPU-side master for the UART memory protocol. A single native memory request
// from the core is turned into a command frame on the byte-wide TX stream. The
// bridge then collects the response from the RX stream and completes the request
// with a one-cycle mem_ready_o pulse. Only one request is outstanding at a time.
// Any protocol problem sets err_o. A timed-out read returns ErrWord, so the core
// never waits forever.
//
// Frames (multi-byte fields least-significant byte first):
//   read  : TX 77, addr[4]          ; RX data[4]
//   write : TX {2,wstrb}, addr[4], wdata[4] ; RX ack (C8)
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   mem_valid_i/mem_ready_o   core request valid / one-cycle completion pulse
//   mem_addr_i, mem_wdata_i   byte address, write data
//   mem_wstrb_i               byte strobes, 0 = read
//   mem_rdata_o               read data, held between reads
//   tx_tdata_o/tvalid/tready  byte stream towards the UART transmitter
//   rx_tdata_i/tvalid/tready  byte stream from the UART receiver (always ready)
//   err_o                     sticky protocol error, cleared only by reset
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for mem_valid_i; request fields are latched on accept
// SEND_CMD  | command byte on TX
// SEND_ADDR | four address bytes on TX
// SEND_DATA | four write-data bytes on TX (writes only)
// RECV_DATA | collecting four read-data bytes, timeout armed
// RECV_ACK  | waiting for the single ack byte, timeout armed
// DONE      | mem_ready_o pulse; no new request is accepted here

module uart_mem_bridge #(
    parameter int unsigned TimeoutCycles = 1000000,
    parameter logic [31:0] ErrWord       = 32'h00100073
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_tdata_o,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    input  logic [7:0]  rx_tdata_i,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        RECV_DATA,
        RECV_ACK,
        DONE
    } state_t;

    localparam logic [7:0] ReadCmd = 8'h77;
    localparam logic [7:0] AckByte = 8'hC8;

    // The timer is a down-counter reloaded with TimeoutCycles-1 whenever a byte
    // moves (TX outside the receive states, or RX). It expires at the terminal
    // count of 1, so a silent responder completes exactly TimeoutCycles cycles
    // after the last byte that moved on either stream.
    localparam int unsigned TimerW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int unsigned TimerLoadInt = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(TimerLoadInt);

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         byte_idx_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic [23:0]        rx_buf_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [TimerW-1:0]  timer_q;

    logic               is_write;
    logic               in_recv;
    logic               last_byte;
    logic               timer_expired;
    logic               tx_fire;

    assign is_write  = (wstrb_q != 4'h0);
    assign in_recv   = (state_q == RECV_DATA) || (state_q == RECV_ACK);
    assign last_byte = (byte_idx_q == 2'd3);
    assign tx_fire   = tx_tvalid_o && tx_tready_i;

    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign timer_expired = (TimeoutCycles != 0) && in_recv && !rx_tvalid_i &&
                           ((timer_q == '0) || (timer_q == TimerW'(1)));

    assign mem_rdata_o = rdata_q;
    assign err_o       = err_q;
    assign rx_tready_o = 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // TX outputs are decoded from the state so a reset drops tx_tvalid_o at once
    // and the byte stays stable for as long as the state is stalled on tready.
    always_comb begin
        state_d     = state_q;
        tx_tvalid_o = 1'b0;
        tx_tdata_o  = 8'h00;
        mem_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    state_d = SEND_CMD;
                end
            end
            SEND_CMD: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = is_write ? {4'h2, wstrb_q} : ReadCmd;
                if (tx_tready_i) begin
                    state_d = SEND_ADDR;
                end
            end
            SEND_ADDR: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = addr_q[{byte_idx_q, 3'b000} +: 8];
                if (tx_tready_i && last_byte) begin
                    state_d = is_write ? SEND_DATA : RECV_DATA;
                end
            end
            SEND_DATA: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = wdata_q[{byte_idx_q, 3'b000} +: 8];
                if (tx_tready_i && last_byte) begin
                    state_d = RECV_ACK;
                end
            end
            RECV_DATA: begin
                if ((rx_tvalid_i && last_byte) || timer_expired) begin
                    state_d = DONE;
                end
            end
            RECV_ACK: begin
                if (rx_tvalid_i || timer_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                mem_ready_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            byte_idx_q <= 2'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            rx_buf_q   <= 24'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            if ((state_q == IDLE) && mem_valid_i) begin
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                wstrb_q <= mem_wstrb_i;
            end

            // The index restarts on every state change, so each field begins at byte 0.
            if (state_d != state_q) begin
                byte_idx_q <= 2'd0;
            end else if ((tx_fire && ((state_q == SEND_ADDR) || (state_q == SEND_DATA))) ||
                         (rx_tvalid_i && (state_q == RECV_DATA))) begin
                byte_idx_q <= byte_idx_q + 2'd1;
            end

            // Partial read data is kept apart from rdata_q, so the core keeps
            // seeing the previous word until the new one is complete.
            if ((state_q == RECV_DATA) && rx_tvalid_i) begin
                case (byte_idx_q)
                    2'd0:    rx_buf_q[7:0]   <= rx_tdata_i;
                    2'd1:    rx_buf_q[15:8]  <= rx_tdata_i;
                    2'd2:    rx_buf_q[23:16] <= rx_tdata_i;
                    default: rdata_q         <= {rx_tdata_i, rx_buf_q};
                endcase
            end else if ((state_q == RECV_DATA) && timer_expired) begin
                rdata_q <= ErrWord;
            end

            if (rx_tvalid_i && !in_recv) begin
                err_q <= 1'b1;
            end
            if ((state_q == RECV_ACK) && rx_tvalid_i && (rx_tdata_i != AckByte)) begin
                err_q <= 1'b1;
            end
            if (timer_expired) begin
                err_q <= 1'b1;
            end

            if (!in_recv || rx_tvalid_i) begin
                timer_q <= TimerLoad;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TimerW'(1);
            end
        end
    end

endmodule
